// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Purpose : bundles the two handshake buses of the instruction-fetch unit.
//           The first is the instruction-memory read channel
//           (req/addr -> ack/rdata). The second is the decoded-stream channel
//           toward the ID stage (valid/instr/pc <- ready).
// Signals : imem_req   fetch unit -> memory, read request (held until ack)
//           imem_addr  fetch unit -> memory, read address
//           imem_ack   memory -> fetch unit, read complete this cycle
//           imem_rdata memory -> fetch unit, instruction word
//           id_valid   fetch unit -> ID, buffer head valid
//           id_instr   fetch unit -> ID, head instruction
//           id_pc      fetch unit -> ID, PC of head instruction
//           id_ready   ID -> fetch unit, head accepted
// Modports: master = fetch-unit side, slave = memory / ID side.
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output id_valid, id_instr, id_pc,
      input  id_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  id_valid, id_instr, id_pc,
      output id_ready
   );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Purpose : instruction-fetch sequencer for the MUSA IF stage.
//           - Issues one outstanding read to instruction memory at pc_in.
//           - Advances the PC when a fetch completes.
//           - Buffers fetched words with their PC tag in a small circular FIFO
//             for the ID stage.
//           - On a branch/jump redirect, flushes the buffer and discards any
//             in-flight read.
// Ports   : clock          rising-edge system clock
//           reset          asynchronous, active-low reset
//           pc_in          current PC (fetch address)
//           pc_write       load pc_next into the PC at the next edge
//           pc_next        next PC value
//           redirect_valid branch/jump taken: flush and refetch
//           redirect_pc    redirect target
//           bus            memory read channel and ID stream (master side)
// ----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter int DEPTH   = 2,
   parameter int PC_STEP = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [31:0]        pc_in,
   output logic               pc_write,
   output logic [31:0]        pc_next,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   if_fetch_unit_if.master    bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               req_q, req_nxt;
   logic [31:0]        addr_q, addr_nxt;
   logic [PTR_W-1:0]   head, tail;
   logic [CNT_W-1:0]   count;
   logic [31:0]        instr_mem [DEPTH];
   logic [31:0]        pc_mem    [DEPTH];
   logic               push;
   logic               pop;
   logic               not_empty;

   assign not_empty = (count != '0);
   assign pop       = not_empty && bus.id_ready;

   // Next-state logic for the fetch sequencer.
   // A new read is only launched when the buffer has room for its result.
   // That room check is what makes FIFO overflow impossible.
   // A redirect in BUSY without ack moves to DISCARD. The request stays up
   // so the memory handshake still completes, and its data is then dropped.
   always_comb begin
      state_nxt = state;
      req_nxt   = req_q;
      addr_nxt  = addr_q;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if ((count < CNT_W'(DEPTH)) && !redirect_valid) begin
               req_nxt   = 1'b1;
               addr_nxt  = pc_in;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (bus.imem_ack) begin
               push      = !redirect_valid;
               req_nxt   = 1'b0;
               state_nxt = IDLE;
            end else if (redirect_valid) begin
               state_nxt = DISCARD;
            end
         end
         DISCARD: begin
            if (bus.imem_ack) begin
               req_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // PC update.
   // A redirect always wins over the sequential increment.
   // The whole pulse is suppressed while reset is held, because a redirect
   // input can be active during reset.
   always_comb begin
      pc_write = reset && (redirect_valid || push);
      pc_next  = redirect_valid ? redirect_pc : (addr_q + 32'(PC_STEP));
   end

   // Sequencer registers.
   // The request and address are registered so memory sees stable values for
   // the whole transaction.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         req_q  <= 1'b0;
         addr_q <= 32'd0;
      end else begin
         state  <= state_nxt;
         req_q  <= req_nxt;
         addr_q <= addr_nxt;
      end
   end

   // FIFO bookkeeping.
   // A flush resets the pointers and the count, and it takes priority over
   // a push or pop in the same cycle.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage.
   // No reset is needed here, because the outputs are masked whenever the
   // buffer is empty.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_mem[tail] <= bus.imem_rdata;
         pc_mem[tail]    <= addr_q;
      end
   end

   // Output drive.
   // The head entry is shown only while valid, so the outputs read zero
   // after reset and whenever the buffer is empty.
   always_comb begin
      bus.imem_req  = req_q;
      bus.imem_addr = addr_q;
      bus.id_valid  = not_empty;
      bus.id_instr  = not_empty ? instr_mem[head] : 32'd0;
      bus.id_pc     = not_empty ? pc_mem[head]    : 32'd0;
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Purpose : self-checking bench for if_fetch_unit.
//           - Directed scenarios run first, followed by a randomized phase.
//           - The reference model is transaction level: a queue of
//             {pc, instr} entries plus a record of the single outstanding
//             read.
//           - The bench owns the architectural PC register that feeds pc_in.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

   localparam int DEPTH   = 2;
   localparam int PC_STEP = 4;

   logic        clock;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_write;
   logic [31:0] pc_next;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   if_fetch_unit_if bus ();

   if_fetch_unit #(.DEPTH(DEPTH), .PC_STEP(PC_STEP)) dut (
      .clock          (clock),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_write       (pc_write),
      .pc_next        (pc_next),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   logic [63:0] fifo[$];
   logic        m_pend;
   logic        m_drop;
   logic [31:0] m_addr;
   logic [31:0] pc_reg;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  tag, actual, expected, $time);
      end
   endtask

   // Reset entry.
   // Outputs are checked immediately after reset asserts, while a redirect
   // is deliberately held high to show that pc_write stays low.
   // The task returns just after a clock edge with reset still asserted.
   task automatic doReset();
      @(negedge clock);
      reset          = 1'b0;
      bus.imem_ack   = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1234;
      #1;
      checkOutput("rst_imem_req",  32'(bus.imem_req), 32'd0);
      checkOutput("rst_imem_addr", bus.imem_addr,     32'd0);
      checkOutput("rst_id_valid",  32'(bus.id_valid), 32'd0);
      checkOutput("rst_id_instr",  bus.id_instr,      32'd0);
      checkOutput("rst_id_pc",     bus.id_pc,         32'd0);
      checkOutput("rst_pc_write",  32'(pc_write),     32'd0);
      fifo.delete();
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_addr = 32'd0;
      pc_reg = 32'd0;
      @(posedge clock);
      @(posedge clock);
   endtask

   // One clock cycle.
   // Inputs are driven at the falling edge and outputs are checked against
   // the model. The model then advances with this cycle's events, and the
   // task returns after the rising edge.
   task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] rpc,
                                input logic ready);
      logic        exp_push;
      logic        exp_pw;
      logic [31:0] exp_pn;
      logic        exp_valid;
      int          sz;
      @(negedge clock);
      reset          = 1'b1;
      pc_in          = pc_reg;
      bus.imem_ack   = ack;
      bus.imem_rdata = rdata;
      bus.id_ready   = ready;
      redirect_valid = redir;
      redirect_pc    = rpc;
      #1;
      exp_push  = m_pend && !m_drop && ack && !redir;
      exp_pw    = redir || exp_push;
      exp_pn    = redir ? rpc : (m_addr + 32'(PC_STEP));
      exp_valid = (fifo.size() != 0);
      checkOutput("imem_req", 32'(bus.imem_req), 32'(m_pend));
      if (m_pend) checkOutput("imem_addr", bus.imem_addr, m_addr);
      checkOutput("pc_write", 32'(pc_write), 32'(exp_pw));
      if (exp_pw) checkOutput("pc_next", pc_next, exp_pn);
      checkOutput("id_valid", 32'(bus.id_valid), 32'(exp_valid));
      if (exp_valid) begin
         checkOutput("id_instr", bus.id_instr, fifo[0][31:0]);
         checkOutput("id_pc",    bus.id_pc,    fifo[0][63:32]);
      end
      sz = fifo.size();
      if (redir) begin
         fifo.delete();
      end else begin
         if (exp_valid && ready) void'(fifo.pop_front());
         if (exp_push) fifo.push_back({m_addr, rdata});
      end
      if (m_pend) begin
         if (ack) m_pend = 1'b0;
         else if (redir) m_drop = 1'b1;
      end else if (sz < DEPTH && !redir) begin
         m_pend = 1'b1;
         m_drop = 1'b0;
         m_addr = pc_reg;
      end
      if (exp_pw) pc_reg = exp_pn;
      @(posedge clock);
   endtask

   // Directed scenarios, then randomized traffic with occasional redirects,
   // stray acks and a mid-run reset.
   initial begin
      int waitc;
      logic a;
      reset          = 1'b0;
      pc_in          = 32'd0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'd0;
      bus.id_ready   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      pc_reg         = 32'd0;

      // Scenario: first fetch after reset, ack two cycles after the request.
      doReset();
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'h2002_0005, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);

      // Scenario: ID stalled, buffer fills and issue stops, then one pop.
      doReset();
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'hAAAA_0002, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'hAAAA_0003, 1'b0, 32'h0, 1'b0);

      // Scenario: redirect while a read is outstanding, late ack dropped.
      applyStimulus(1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b1, 32'h0000_0040, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);

      // Scenario: redirect in the same cycle as the ack.
      applyStimulus(1'b1, 32'hBBBB_0001, 1'b1, 32'h0000_0080, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b1);

      // Scenario: PC wrap at the top of memory, then push+pop together.
      applyStimulus(1'b1, 32'hCCCC_0040, 1'b1, 32'hFFFF_FFFC, 1'b0);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'hCCCC_0001, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'hCCCC_0002, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);

      // Scenario: reset while busy with a non-empty buffer, stray ack after.
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);
      doReset();
      applyStimulus(1'b1, 32'hEEEE_0001, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0,         1'b0, 32'h0, 1'b0);

      // Randomized traffic.
      waitc = 0;
      for (int i = 0; i < 800; i++) begin
         if (i == 400) doReset();
         if (m_pend) begin
            if (waitc == 0) begin
               a     = 1'b1;
               waitc = $urandom_range(0, 3);
            end else begin
               a     = 1'b0;
               waitc = waitc - 1;
            end
         end else begin
            a = ($urandom_range(0, 15) == 0);
         end
         applyStimulus(a, $urandom, ($urandom_range(0, 9) == 0),
                       {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                       ($urandom_range(0, 2) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
